// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: I-cache read port, execute redirect and decode slot handshake.
interface instr_fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] pc;

  modport master (
    output imem_read, imem_address, ir_valid, ir, pc,
    input  imem_rdata, imem_resp, redirect, redirect_target, ir_ready
  );

  modport slave (
    input  imem_read, imem_address, ir_valid, ir, pc,
    output imem_rdata, imem_resp, redirect, redirect_target, ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding I-cache read, a one-entry output slot
// and a one-entry pend buffer that absorbs a response arriving while decode stalls.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_unit_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic        ir_valid_q;
  logic [31:0] pend_ir;
  logic [31:0] pend_pc;

  logic [31:0] target;
  logic [31:0] next_pc;
  logic        slot_free;

  assign target    = {bus.redirect_target[31:2], 2'b00};
  assign next_pc   = fetch_pc + 32'd4;
  assign slot_free = !ir_valid_q || bus.ir_ready;

  assign bus.imem_read    = ((state == FETCH) || (state == FLUSH)) && rst_n;
  assign bus.imem_address = req_addr;
  assign bus.ir_valid     = ir_valid_q;
  assign bus.ir           = ir_q;
  assign bus.pc           = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      ir_q       <= NOP_INSN;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      pend_ir    <= NOP_INSN;
      pend_pc    <= RESET_PC;
    end else begin
      // Consumption and redirect both empty the slot; a load below overrides.
      if ((ir_valid_q && bus.ir_ready) || bus.redirect) ir_valid_q <= 1'b0;

      case (state)
        FETCH: begin
          if (bus.imem_resp && bus.redirect) begin
            fetch_pc <= target;
            req_addr <= target;
          end else if (bus.imem_resp) begin
            fetch_pc <= next_pc;
            req_addr <= next_pc;
            if (slot_free) begin
              ir_q       <= bus.imem_rdata;
              pc_q       <= fetch_pc;
              ir_valid_q <= 1'b1;
            end else begin
              pend_ir <= bus.imem_rdata;
              pend_pc <= fetch_pc;
              state   <= DRAIN;
            end
          end else if (bus.redirect) begin
            // Request in flight must complete at its old address before refetching.
            fetch_pc <= target;
            state    <= FLUSH;
          end
        end
        DRAIN: begin
          if (bus.redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= FETCH;
          end else if (bus.ir_ready) begin
            ir_q       <= pend_ir;
            pc_q       <= pend_pc;
            ir_valid_q <= 1'b1;
            state      <= FETCH;
          end
        end
        FLUSH: begin
          if (bus.imem_resp && bus.redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= FETCH;
          end else if (bus.imem_resp) begin
            req_addr <= fetch_pc;
            state    <= FETCH;
          end else if (bus.redirect) begin
            fetch_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
